// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main control and ALU control decoder.
// Optional addi support is enabled with MIPS_CTRL_ADDI_EN.
package mips_ctrl_pkg;

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_FETCH   = 4'd1;
  localparam logic [3:0] ST_DECODE  = 4'd2;
  localparam logic [3:0] ST_MEMADR  = 4'd3;
  localparam logic [3:0] ST_MEMRD   = 4'd4;
  localparam logic [3:0] ST_MEMWB   = 4'd5;
  localparam logic [3:0] ST_MEMWR   = 4'd6;
  localparam logic [3:0] ST_EXEC    = 4'd7;
  localparam logic [3:0] ST_RWB     = 4'd8;
  localparam logic [3:0] ST_BRANCH  = 4'd9;
  localparam logic [3:0] ST_JUMP    = 4'd10;
  localparam logic [3:0] ST_ADDI_EX = 4'd11;
  localparam logic [3:0] ST_ADDI_WB = 4'd12;

  typedef enum logic [3:0] {
    S_IDLE    = ST_IDLE,
    S_FETCH   = ST_FETCH,
    S_DECODE  = ST_DECODE,
    S_MEMADR  = ST_MEMADR,
    S_MEMRD   = ST_MEMRD,
    S_MEMWB   = ST_MEMWB,
    S_MEMWR   = ST_MEMWR,
    S_EXEC    = ST_EXEC,
    S_RWB     = ST_RWB,
    S_BRANCH  = ST_BRANCH,
    S_JUMP    = ST_JUMP
`ifdef MIPS_CTRL_ADDI_EN
    ,
    S_ADDI_EX = ST_ADDI_EX,
    S_ADDI_WB = ST_ADDI_WB
`endif
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  // ALUOp is also consumed by the ALU control decoder; keep these in sync there.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

endpackage

// File: rtl/mips_ctrl_if.sv
// Control <-> datapath bundle: instruction/memory status in, enables and selects out.
interface mips_ctrl_if #(parameter int STATE_W = 4);
  logic [5:0]         opcode;
  logic               mem_ready;
  logic               zero;
  logic               pc_write;
  logic               pc_write_cond;
  logic               iord;
  logic               mem_read;
  logic               mem_write;
  logic               ir_write;
  logic               mem_to_reg;
  logic               reg_dst;
  logic               reg_write;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [1:0]         alu_op;
  logic [1:0]         pc_source;
  logic               illegal_op;
  logic [STATE_W-1:0] state_dbg;

  modport master (
    input  opcode, mem_ready, zero,
    output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op, state_dbg
  );

  modport slave (
    output opcode, mem_ready, zero,
    input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op, state_dbg
  );
endinterface

// File: rtl/mips_ctrl_decode.sv
// Pure state -> control-vector decode for the multicycle main control.
// ADDI states are decoded only when MIPS_CTRL_ADDI_EN is defined.
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_e state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        // ir_write/pc_write are qualified by mem_ready in the top.
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.pc_write  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMMSH2;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_RWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
`ifdef MIPS_CTRL_ADDI_EN
      S_ADDI_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_ADDI_WB: begin
        ctrl.reg_write = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS: state register, next-state and illegal-op pulse.
// Define MIPS_CTRL_ADDI_EN to add the ADDI_EX/ADDI_WB path for opcode 001000.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  mips_ctrl_if.master cif
);

  state_e state;
  ctrl_t  dec;
  logic   illegal_q;
  logic   in_fetch;
  logic   unused_zero;

  // Branch resolution happens in the datapath through pc_write_cond.
  assign unused_zero = cif.zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= 1'b0;
      case (state)
        S_IDLE:   state <= S_FETCH;
        S_FETCH:  if (cif.mem_ready) state <= S_DECODE;
        S_DECODE: begin
          case (cif.opcode)
            OP_LW, OP_SW: state <= S_MEMADR;
            OP_R:         state <= S_EXEC;
            OP_BEQ:       state <= S_BRANCH;
            OP_J:         state <= S_JUMP;
`ifdef MIPS_CTRL_ADDI_EN
            OP_ADDI:      state <= S_ADDI_EX;
`endif
            default: begin
              state     <= S_FETCH;
              illegal_q <= 1'b1;
            end
          endcase
        end
        S_MEMADR: state <= (cif.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:  if (cif.mem_ready) state <= S_MEMWB;
        S_MEMWB:  state <= S_FETCH;
        S_MEMWR:  if (cif.mem_ready) state <= S_FETCH;
        S_EXEC:   state <= S_RWB;
        S_RWB:    state <= S_FETCH;
        S_BRANCH: state <= S_FETCH;
        S_JUMP:   state <= S_FETCH;
`ifdef MIPS_CTRL_ADDI_EN
        S_ADDI_EX: state <= S_ADDI_WB;
        S_ADDI_WB: state <= S_FETCH;
`endif
        default:  state <= S_IDLE;
      endcase
    end
  end

  mips_ctrl_decode u_decode (
    .state (state),
    .ctrl  (dec)
  );

  // The fetch-side loads must wait for the memory to return the instruction.
  assign in_fetch = (state == S_FETCH);

  assign cif.pc_write      = dec.pc_write & (~in_fetch | cif.mem_ready);
  assign cif.ir_write      = dec.ir_write & (~in_fetch | cif.mem_ready);
  assign cif.pc_write_cond = dec.pc_write_cond;
  assign cif.iord          = dec.iord;
  assign cif.mem_read      = dec.mem_read;
  assign cif.mem_write     = dec.mem_write;
  assign cif.mem_to_reg    = dec.mem_to_reg;
  assign cif.reg_dst       = dec.reg_dst;
  assign cif.reg_write     = dec.reg_write;
  assign cif.alu_src_a     = dec.alu_src_a;
  assign cif.alu_src_b     = dec.alu_src_b;
  assign cif.alu_op        = dec.alu_op;
  assign cif.pc_source     = dec.pc_source;
  assign cif.illegal_op    = illegal_q;
  assign cif.state_dbg     = STATE_W'(state);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: per-cycle expected state/controls queued with stimulus.
// Honours MIPS_CTRL_ADDI_EN for the expected behaviour of opcode 001000.
module tb_mips_multicycle_ctrl;
  import mips_ctrl_pkg::*;

  localparam int STATE_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mips_ctrl_if #(.STATE_W(STATE_W)) cif ();

  mips_multicycle_ctrl #(.STATE_W(STATE_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cif   (cif)
  );

  typedef struct packed { logic [5:0] op; logic mr; } stim_t;
  typedef struct packed { logic [3:0] st; logic [16:0] ctl; } exp_t;

  stim_t stim_q[$];
  exp_t  exp_q[$];
  logic  ill_pend = 1'b0;
  int    n_chk = 0;
  int    n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [16:0] obs();
    return {cif.pc_write, cif.pc_write_cond, cif.iord, cif.mem_read, cif.mem_write,
            cif.ir_write, cif.mem_to_reg, cif.reg_dst, cif.reg_write, cif.alu_src_a,
            cif.alu_src_b, cif.alu_op, cif.pc_source, cif.illegal_op};
  endfunction

  // Reference control table written from the state descriptions.
  function automatic logic [16:0] model(input logic [3:0] st, input logic mr, input logic ill);
    logic pw, pwc, iord, mrd, mwr, irw, m2r, rd, rw, asa;
    logic [1:0] asb, aop, pcs;
    {pw, pwc, iord, mrd, mwr, irw, m2r, rd, rw, asa} = '0;
    asb = 2'b00; aop = 2'b00; pcs = 2'b00;
    case (st)
      ST_FETCH:  begin mrd = 1; asb = 2'b01; irw = mr; pw = mr; end
      ST_DECODE: asb = 2'b11;
      ST_MEMADR: begin asa = 1; asb = 2'b10; end
      ST_MEMRD:  begin mrd = 1; iord = 1; end
      ST_MEMWB:  begin rw = 1; m2r = 1; end
      ST_MEMWR:  begin mwr = 1; iord = 1; end
      ST_EXEC:   begin asa = 1; aop = 2'b10; end
      ST_RWB:    begin rw = 1; rd = 1; end
      ST_BRANCH: begin asa = 1; aop = 2'b01; pwc = 1; pcs = 2'b01; end
      ST_JUMP:   begin pw = 1; pcs = 2'b10; end
`ifdef MIPS_CTRL_ADDI_EN
      ST_ADDI_EX: begin asa = 1; asb = 2'b10; end
      ST_ADDI_WB: rw = 1;
`endif
      default: ;
    endcase
    return {pw, pwc, iord, mrd, mwr, irw, m2r, rd, rw, asa, asb, aop, pcs, ill};
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(1, 0));
  endfunction

  task automatic push(input logic [5:0] op, input logic mr, input logic [3:0] st);
    logic ill;
    ill = (st == ST_FETCH) ? ill_pend : 1'b0;
    if (st == ST_FETCH) ill_pend = 1'b0;
    stim_q.push_back({op, mr});
    exp_q.push_back({st, model(st, mr, ill)});
  endtask

  // One instruction: fwait stalled fetch cycles, mwait stalled memory cycles.
  task automatic instr(input logic [5:0] op, input int fwait, input int mwait);
    for (int i = 0; i < fwait; i++) push(op, 1'b0, ST_FETCH);
    push(op, 1'b1, ST_FETCH);
    push(op, rnd(), ST_DECODE);
    case (op)
      6'b100011: begin
        push(op, rnd(), ST_MEMADR);
        for (int i = 0; i < mwait; i++) push(op, 1'b0, ST_MEMRD);
        push(op, 1'b1, ST_MEMRD);
        push(op, rnd(), ST_MEMWB);
      end
      6'b101011: begin
        push(op, rnd(), ST_MEMADR);
        for (int i = 0; i < mwait; i++) push(op, 1'b0, ST_MEMWR);
        push(op, 1'b1, ST_MEMWR);
      end
      6'b000000: begin push(op, rnd(), ST_EXEC); push(op, rnd(), ST_RWB); end
      6'b000100: push(op, rnd(), ST_BRANCH);
      6'b000010: push(op, rnd(), ST_JUMP);
`ifdef MIPS_CTRL_ADDI_EN
      6'b001000: begin push(op, rnd(), ST_ADDI_EX); push(op, rnd(), ST_ADDI_WB); end
`endif
      default: ill_pend = 1'b1;
    endcase
  endtask

  task automatic run_queue();
    while (stim_q.size() != 0) begin
      stim_t s;
      exp_t  e;
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      cif.opcode    = s.op;
      cif.mem_ready = s.mr;
      #1;
      chk("state", 32'(cif.state_dbg), 32'(e.st));
      chk("ctl", 32'(obs()), 32'(e.ctl));
      chk("rdwr_excl", 32'(cif.mem_read & cif.mem_write), 32'd0);
      @(posedge clk);
      #1;
    end
  endtask

  logic [5:0] ops [7];

  initial begin
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b111111, 6'b001000};
    cif.opcode = 6'b0; cif.mem_ready = 1'b0; cif.zero = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'(cif.state_dbg), 32'(ST_IDLE));
    chk("rst_ctl", 32'(obs()), 32'd0);
    cif.mem_ready = 1'b1;
    #1;
    chk("rst_ctl_mr", 32'(obs()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("idle_state", 32'(cif.state_dbg), 32'(ST_IDLE));
    chk("idle_ctl", 32'(obs()), 32'd0);
    @(posedge clk);
    #1;

    instr(6'b000000, 0, 0);   // R
    instr(6'b000100, 0, 0);   // beq
    instr(6'b100011, 0, 3);   // lw, 3 memory stalls
    instr(6'b101011, 0, 2);   // sw, 2 memory stalls
    instr(6'b000010, 1, 0);   // j, 1 fetch stall
    instr(6'b111111, 0, 0);   // illegal
    instr(6'b101011, 2, 0);   // illegal pulse lands on a stalled fetch
    instr(6'b001000, 0, 0);   // addi or illegal depending on build
    instr(6'b100011, 0, 0);
    instr(6'b000000, 0, 0);
    run_queue();

    // Reset in the middle of a stalled lw read.
    push(6'b100011, 1'b1, ST_FETCH);
    push(6'b100011, 1'b1, ST_DECODE);
    push(6'b100011, 1'b0, ST_MEMADR);
    push(6'b100011, 1'b0, ST_MEMRD);
    push(6'b100011, 1'b0, ST_MEMRD);
    run_queue();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_state", 32'(cif.state_dbg), 32'(ST_IDLE));
    chk("midrst_ctl", 32'(obs()), 32'd0);
    cif.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rsthold_state", 32'(cif.state_dbg), 32'(ST_IDLE));
    chk("rsthold_ctl", 32'(obs()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_state", 32'(cif.state_dbg), 32'(ST_IDLE));
    @(posedge clk);
    #1;
    ill_pend = 1'b0;
    instr(6'b100011, 0, 1);
    instr(6'b000000, 0, 0);

    for (int k = 0; k < 12; k++)
      instr(ops[$urandom_range(6, 0)], $urandom_range(2, 0), $urandom_range(2, 0));
    run_queue();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
